rv32i_core: RTL and testbench
=============================

// Module: rv32i_core
// PURPOSE
// - Single-cycle RV32I integer core: fetches one instruction per clk and executes it in the same cycle.
// - Commits PC, register file and store on the next rising edge.
// - Talks to a unified word RAM through separate instruction/data ports; the RAM reads asynchronously and writes on clk.
// - Raises a sticky exit flag when the program stores 0xDEADBEEF to 0x100C.
// PARAMETERS
// - RESET_PC   32'h0000_0000   PC value loaded on reset
// - EXIT_ADDR  32'h0000_100C   store address that signals program end
// - EXIT_DATA  32'hDEAD_BEEF   store data that signals program end
// PORTS
// - clk         in   1   single clock; all state updates on rising edge
// - rst         in   1   synchronous, active-high reset
// - exit        out  1   program-finished flag (registered, sticky)
// - imem_addr   out  32  fetch byte address (= pc)
// - imem_inst   in   32  instruction at imem_addr; combinational, same cycle
// - dmem_addr   out  32  data byte address; 0 when no load/store
// - dmem_wen    out  1   store enable, sampled by RAM on rising clk
// - dmem_wdata  out  32  store data (rs2)
// - dmem_rdata  in   32  load data at dmem_addr; combinational, same cycle
// BEHAVIOUR
// - Reset (rst=1 at edge): pc<=RESET_PC, exit<=0, x1..x31<=0.
//   - Outputs during reset follow the combinational decode of imem_inst, except dmem_wen is forced 0.
// - pc is a register named `pc`; the bench reads it hierarchically.
// - Each cycle: decode imem_inst, read rs1/rs2, compute, then at the edge write rd and update pc.
//   - Default next pc = pc+4.
// - Supported instructions:
//   - LUI, AUIPC, JAL, JALR
//   - BEQ/BNE/BLT/BGE/BLTU/BGEU
//   - LW, SW
//   - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI
//   - ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA
// - Any other encoding (incl. LB/LH/SB/SH, FENCE, SYSTEM) executes as a NOP: pc+4, no writes.
// - Immediates are sign-extended per the I/S/B/U/J formats. Shift amount = low 5 bits. SRA/SRAI is arithmetic.
// - Arithmetic is modulo 2^32; overflow is ignored.
// - JAL/JALR: rd<=pc+4. JALR target = (rs1+imm) & ~1. Branch/JAL target = pc+imm.
// - Misaligned targets are not trapped; the PC uses the computed value as-is.
// - x0 always reads 0; writes to x0 are discarded.
// - The register file has 2 async read ports and 1 sync write port.
// - Write-then-read in the same cycle returns the old value; the new value is visible next cycle.
// - LW: dmem_addr = rs1+imm, rd <= dmem_rdata.
// - SW: dmem_addr = rs1+imm, dmem_wdata = rs2, dmem_wen = 1 for exactly that cycle.
// - Word access only; the low 2 address bits are passed through unchanged and the RAM ignores them.
// - Non-memory instruction: dmem_addr=0, dmem_wen=0, dmem_wdata=0.
// - Exit: a SW with address EXIT_ADDR and data EXIT_DATA sets exit<=1 at that edge.
//   - The store itself is still performed.
//   - exit stays 1 until rst.
//   - While exit=1: pc is frozen, register writes are blocked and dmem_wen is held 0.
// - Reset asserted mid-program overrides everything at the next edge. The RAM contents are not cleared.
// STRUCTURE
// - Package rv32i_pkg holds:
//   - opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG)
//   - funct3/funct7 constants
//   - alu_op_e enum
//   - imm-format enum
// - One sub-module: rv32i_regfile (32x32, x0 hardwired, 2R/1W, sync reset of contents).
// - Decode, ALU, branch compare and next-pc logic stay in rv32i_core.
// TESTING
// - Reset: hold rst 2 cycles -> pc=0, exit=0, dmem_wen=0. After release, pc steps 0,4,8 over NOPs (0x00000013).
// - ALU: ADDI x1,x0,-1; SRLI x2,x1,4; SRAI x3,x1,4; SLTU x4,x0,x1 -> x1=0xFFFFFFFF, x2=0x0FFFFFFF, x3=0xFFFFFFFF, x4=1.
// - Memory: LUI x5,0x1; ADDI x6,x0,0x55; SW x6,8(x5); LW x7,8(x5).
//   - SW cycle: dmem_addr=0x1008, dmem_wen=1, dmem_wdata=0x55.
//   - LW result: x7=0x55.
// - Control: BEQ x0,x0,+8 skips one instruction (pc 0->8).
//   - JAL x1,+12 at pc 0x10 -> pc=0x1C, x1=0x14.
//   - JALR x0,0(x1) -> pc=0x14.
// - x0 write: ADDI x0,x0,5; ADD x8,x0,x0 -> x8=0.
// - Exit: store 0xDEADBEEF to 0x100C -> exit=1 after that edge.
//   - pc frozen on the following cycles.
//   - A store to 0x100C with data 0x1234 leaves exit=0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings, decode enums and immediate/ALU helpers for the
// single-cycle core.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;
  typedef enum logic [1:0] {OPA_RS1, OPA_PC, OPA_ZERO} opa_sel_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = {{20{inst[31]}}, inst[31:20]};
    endcase
    return imm;
  endfunction

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// 32x32 integer register file: x0 reads as zero, two async read ports,
// one write port committed on the rising edge, contents cleared on reset.
module rv32i_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  input  logic        i_wen,
  input  logic [4:0]  i_rd_addr,
  input  logic [31:0] i_rd_data
);

  logic [31:0] r_regs [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_wen && (i_rd_addr != 5'd0)) begin
      r_regs[i_rd_addr] <= i_rd_data;
    end
  end

  // No write bypass: a same-cycle write is seen only on the next cycle
  assign o_rs1_data = (i_rs1_addr == 5'd0) ? 32'd0 : r_regs[i_rs1_addr];
  assign o_rs2_data = (i_rs2_addr == 5'd0) ? 32'd0 : r_regs[i_rs2_addr];

endmodule

// File: rtl/rv32i_core.sv
// Single-cycle RV32I core: decode, ALU, branch compare and next-pc in one
// cycle; pc, register file and exit flag commit on the rising edge.
module rv32i_core
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] EXIT_ADDR = 32'h0000_100C,
  parameter logic [31:0] EXIT_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        exit,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic [31:0] dmem_addr,
  output logic        dmem_wen,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);

  logic [31:0] pc;
  logic        r_exit;

  logic [6:0]  w_opcode, w_f7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;

  logic        w_valid, w_use_imm, w_rd_wen;
  logic        w_is_branch, w_is_jal, w_is_jalr, w_is_load, w_is_store;
  alu_op_e     w_alu_op;
  imm_fmt_e    w_imm_fmt;
  opa_sel_e    w_opa_sel;
  wb_sel_e     w_wb_sel;

  logic [31:0] w_imm, w_rs1_data, w_rs2_data, w_op_a, w_op_b, w_alu_res;
  logic [31:0] w_pc_plus4, w_pc_imm, w_next_pc, w_rd_data;
  logic        w_br_taken, w_exit_hit, w_rf_wen;

  assign w_opcode = imem_inst[6:0];
  assign w_rd     = imem_inst[11:7];
  assign w_f3     = imem_inst[14:12];
  assign w_rs1    = imem_inst[19:15];
  assign w_rs2    = imem_inst[24:20];
  assign w_f7     = imem_inst[31:25];

  // Unrecognised encodings leave every enable low, so they retire as NOPs
  always_comb begin
    w_valid     = 1'b0;
    w_use_imm   = 1'b1;
    w_rd_wen    = 1'b0;
    w_is_branch = 1'b0;
    w_is_jal    = 1'b0;
    w_is_jalr   = 1'b0;
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_alu_op    = ALU_ADD;
    w_imm_fmt   = IMM_I;
    w_opa_sel   = OPA_RS1;
    w_wb_sel    = WB_ALU;
    case (w_opcode)
      OP_LUI: begin
        w_valid = 1'b1; w_imm_fmt = IMM_U; w_opa_sel = OPA_ZERO;
      end
      OP_AUIPC: begin
        w_valid = 1'b1; w_imm_fmt = IMM_U; w_opa_sel = OPA_PC;
      end
      OP_JAL: begin
        w_valid = 1'b1; w_imm_fmt = IMM_J; w_wb_sel = WB_PC4; w_is_jal = 1'b1;
      end
      OP_JALR: begin
        w_valid = (w_f3 == F3_JALR); w_wb_sel = WB_PC4; w_is_jalr = w_valid;
      end
      OP_BRANCH: begin
        w_valid     = (w_f3 != 3'b010) && (w_f3 != 3'b011);
        w_imm_fmt   = IMM_B;
        w_is_branch = w_valid;
      end
      OP_LOAD: begin
        w_valid = (w_f3 == F3_LW); w_wb_sel = WB_MEM; w_is_load = w_valid;
      end
      OP_STORE: begin
        w_valid = (w_f3 == F3_SW); w_imm_fmt = IMM_S; w_is_store = w_valid;
      end
      OP_IMM: begin
        if (w_f3 == F3_SLL)     w_valid = (w_f7 == F7_BASE);
        else if (w_f3 == F3_SR) w_valid = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
        else                    w_valid = 1'b1;
        w_alu_op = alu_from_f3(w_f3, (w_f3 == F3_SR) && w_f7[5]);
      end
      OP_REG: begin
        w_use_imm = 1'b0;
        w_valid   = (w_f7 == F7_BASE) ||
                    ((w_f7 == F7_ALT) && ((w_f3 == F3_ADD) || (w_f3 == F3_SR)));
        w_alu_op  = alu_from_f3(w_f3, w_f7[5]);
      end
      default: w_valid = 1'b0;
    endcase
    w_rd_wen = w_valid && !w_is_branch && !w_is_store;
  end

  assign w_imm = gen_imm(imem_inst, w_imm_fmt);

  rv32i_regfile u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_rs1_addr (w_rs1),
    .i_rs2_addr (w_rs2),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data),
    .i_wen      (w_rf_wen),
    .i_rd_addr  (w_rd),
    .i_rd_data  (w_rd_data)
  );

  always_comb begin
    case (w_opa_sel)
      OPA_PC:   w_op_a = pc;
      OPA_ZERO: w_op_a = 32'd0;
      default:  w_op_a = w_rs1_data;
    endcase
  end
  assign w_op_b = w_use_imm ? w_imm : w_rs2_data;

  always_comb begin
    case (w_alu_op)
      ALU_SUB:  w_alu_res = w_op_a - w_op_b;
      ALU_SLL:  w_alu_res = w_op_a << w_op_b[4:0];
      ALU_SLT:  w_alu_res = {31'd0, $signed(w_op_a) < $signed(w_op_b)};
      ALU_SLTU: w_alu_res = {31'd0, w_op_a < w_op_b};
      ALU_XOR:  w_alu_res = w_op_a ^ w_op_b;
      ALU_SRL:  w_alu_res = w_op_a >> w_op_b[4:0];
      ALU_SRA:  w_alu_res = $unsigned($signed(w_op_a) >>> w_op_b[4:0]);
      ALU_OR:   w_alu_res = w_op_a | w_op_b;
      ALU_AND:  w_alu_res = w_op_a & w_op_b;
      default:  w_alu_res = w_op_a + w_op_b;
    endcase
  end

  always_comb begin
    case (w_f3)
      F3_BEQ:  w_br_taken = (w_rs1_data == w_rs2_data);
      F3_BNE:  w_br_taken = (w_rs1_data != w_rs2_data);
      F3_BLT:  w_br_taken = ($signed(w_rs1_data) < $signed(w_rs2_data));
      F3_BGE:  w_br_taken = ($signed(w_rs1_data) >= $signed(w_rs2_data));
      F3_BLTU: w_br_taken = (w_rs1_data < w_rs2_data);
      F3_BGEU: w_br_taken = (w_rs1_data >= w_rs2_data);
      default: w_br_taken = 1'b0;
    endcase
  end

  assign w_pc_plus4 = pc + 32'd4;
  assign w_pc_imm   = pc + w_imm;

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (w_is_jal || (w_is_branch && w_br_taken)) w_next_pc = w_pc_imm;
    else if (w_is_jalr)                          w_next_pc = {w_alu_res[31:1], 1'b0};
  end

  always_comb begin
    case (w_wb_sel)
      WB_MEM:  w_rd_data = dmem_rdata;
      WB_PC4:  w_rd_data = w_pc_plus4;
      default: w_rd_data = w_alu_res;
    endcase
  end

  assign w_rf_wen   = w_rd_wen && !r_exit;
  assign w_exit_hit = w_is_store && !r_exit &&
                      (w_alu_res == EXIT_ADDR) && (w_rs2_data == EXIT_DATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      r_exit <= 1'b0;
    end else begin
      if (!r_exit)   pc     <= w_next_pc;
      if (w_exit_hit) r_exit <= 1'b1;
    end
  end

  assign exit       = r_exit;
  assign imem_addr  = pc;
  assign dmem_addr  = (w_is_load || w_is_store) ? w_alu_res : 32'd0;
  assign dmem_wdata = w_is_store ? w_rs2_data : 32'd0;
  assign dmem_wen   = w_is_store && !rst && !r_exit;

endmodule

// File: tb/tb_rv32i_core.sv
// Bench for rv32i_core: unified word RAM model, small hand-assembled
// programs, store scoreboard plus direct pc/exit checks.
module tb_rv32i_core;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exit;
  logic [31:0] imem_addr, imem_inst, dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_wen;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:2047];
  logic        ld_we = 1'b0;
  logic [10:0] ld_idx = '0;
  logic [31:0] ld_data = '0;
  logic [31:0] prog_q[$];
  logic [63:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  rv32i_core dut (
    .clk        (clk),
    .rst        (rst),
    .exit       (exit),
    .imem_addr  (imem_addr),
    .imem_inst  (imem_inst),
    .dmem_addr  (dmem_addr),
    .dmem_wen   (dmem_wen),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata)
  );

  assign imem_inst  = mem[imem_addr[12:2]];
  assign dmem_rdata = mem[dmem_addr[12:2]];

  always @(posedge clk) begin
    if (ld_we)         mem[ld_idx] <= ld_data;
    else if (dmem_wen) mem[dmem_addr[12:2]] <= dmem_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard: every committed store must match the next expected {addr,data}
  always @(negedge clk) begin
    if (dmem_wen) begin
      chk("store_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) chk("store", {dmem_addr, dmem_wdata}, exp_q.pop_front());
    end
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_REG};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
  endfunction

  // driver tasks
  task automatic load_prog();
    rst = 1'b1;
    for (int i = 0; i < prog_q.size(); i++) begin
      ld_we   = 1'b1;
      ld_idx  = 11'(i);
      ld_data = prog_q[i];
      @(negedge clk);
    end
    ld_we = 1'b0;
    prog_q.delete();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    rst = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic sw_exp(input logic [4:0] rs2, input logic [11:0] off, input logic [31:0] data);
    prog_q.push_back(enc_s(off, rs2, 5'd0, F3_SW));
    exp_q.push_back({20'd0, off, data});
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] pc_exp [12] = '{32'h00, 32'h08, 32'h0C, 32'h10, 32'h1C, 32'h20,
                               32'h14, 32'h24, 32'h28, 32'h30, 32'h34, 32'h34};

  initial begin
    logic [11:0] rnd;

    // reset: a SW at pc 0 must decode but not write
    prog_q.push_back(enc_s(12'h020, 5'd0, 5'd0, F3_SW));
    load_prog();
    @(negedge clk);
    chk("rst_pc", 64'(dut.pc), 64'h0);
    chk("rst_exit", 64'(exit), 64'h0);
    chk("rst_wen", 64'(dmem_wen), 64'h0);
    chk("rst_addr", 64'(dmem_addr), 64'h20);

    repeat (4) prog_q.push_back(NOP);
    load_prog();
    rst = 1'b0;
    chk("nop_pc0", 64'(dut.pc), 64'h0);
    @(negedge clk);
    chk("nop_pc4", 64'(dut.pc), 64'h4);
    @(negedge clk);
    chk("nop_pc8", 64'(dut.pc), 64'h8);

    // ALU, x0 and unsupported encodings
    prog_q.push_back(enc_i(12'hFFF, 5'd0, F3_ADD, 5'd1, OP_IMM));
    prog_q.push_back(enc_i({7'h00, 5'd4}, 5'd1, F3_SR, 5'd2, OP_IMM));
    prog_q.push_back(enc_i({7'h20, 5'd4}, 5'd1, F3_SR, 5'd3, OP_IMM));
    prog_q.push_back(enc_r(F7_BASE, 5'd1, 5'd0, F3_SLTU, 5'd4));
    prog_q.push_back(enc_i(12'd5, 5'd0, F3_ADD, 5'd0, OP_IMM));
    prog_q.push_back(enc_r(F7_BASE, 5'd0, 5'd0, F3_ADD, 5'd8));
    prog_q.push_back(enc_r(F7_ALT, 5'd1, 5'd0, F3_ADD, 5'd9));
    prog_q.push_back(enc_r(F7_BASE, 5'd0, 5'd1, F3_SLT, 5'd10));
    prog_q.push_back(enc_i(12'h0F0, 5'd1, F3_XOR, 5'd11, OP_IMM));
    prog_q.push_back(enc_i(12'd0, 5'd0, 3'b001, 5'd12, OP_LOAD));
    prog_q.push_back(enc_s(12'h240, 5'd1, 5'd0, 3'b000));
    prog_q.push_back(32'h0000_0073);
    sw_exp(5'd1,  12'h200, 32'hFFFF_FFFF);
    sw_exp(5'd2,  12'h204, 32'h0FFF_FFFF);
    sw_exp(5'd3,  12'h208, 32'hFFFF_FFFF);
    sw_exp(5'd4,  12'h20C, 32'h1);
    sw_exp(5'd8,  12'h210, 32'h0);
    sw_exp(5'd9,  12'h214, 32'h1);
    sw_exp(5'd10, 12'h218, 32'h1);
    sw_exp(5'd11, 12'h21C, 32'hFFFF_FF0F);
    sw_exp(5'd12, 12'h220, 32'h0);
    prog_q.push_back(enc_j(21'd0, 5'd0));
    load_prog();
    run(28);
    chk("drain_alu", 64'(exp_q.size()), 64'd0);

    // memory path plus AUIPC and a random immediate
    rnd = 12'($urandom_range(0, 2047));
    prog_q.push_back(enc_u(20'h1, 5'd5, OP_LUI));
    prog_q.push_back(enc_i(12'h055, 5'd0, F3_ADD, 5'd6, OP_IMM));
    prog_q.push_back(enc_s(12'h008, 5'd6, 5'd5, F3_SW));
    exp_q.push_back({32'h1008, 32'h55});
    prog_q.push_back(enc_i(12'h008, 5'd5, F3_LW, 5'd7, OP_LOAD));
    sw_exp(5'd7, 12'h204, 32'h55);
    prog_q.push_back(enc_u(20'h2, 5'd9, OP_AUIPC));
    sw_exp(5'd9, 12'h208, 32'h2014);
    prog_q.push_back(enc_i({7'h00, 5'd4}, 5'd6, F3_SLL, 5'd12, OP_IMM));
    sw_exp(5'd12, 12'h20C, 32'h550);
    prog_q.push_back(enc_i(rnd, 5'd0, F3_ADD, 5'd13, OP_IMM));
    sw_exp(5'd13, 12'h210, {20'd0, rnd});
    prog_q.push_back(enc_j(21'd0, 5'd0));
    load_prog();
    run(16);
    chk("drain_mem", 64'(exp_q.size()), 64'd0);

    // control flow with a pc trace
    prog_q.push_back(enc_b(13'd8, 5'd0, 5'd0, F3_BEQ));
    prog_q.push_back(enc_i(12'd1, 5'd0, F3_ADD, 5'd20, OP_IMM));
    prog_q.push_back(enc_i(12'd3, 5'd0, F3_ADD, 5'd21, OP_IMM));
    prog_q.push_back(enc_b(13'd8, 5'd0, 5'd21, F3_BLT));
    prog_q.push_back(enc_j(21'd12, 5'd1));
    prog_q.push_back(enc_j(21'h10, 5'd0));
    prog_q.push_back(enc_i(12'd2, 5'd0, F3_ADD, 5'd20, OP_IMM));
    sw_exp(5'd1, 12'h200, 32'h14);
    prog_q.push_back(enc_i(12'd1, 5'd1, F3_JALR, 5'd0, OP_JALR));
    sw_exp(5'd20, 12'h204, 32'h0);
    prog_q.push_back(enc_b(13'd8, 5'd21, 5'd0, F3_BLTU));
    prog_q.push_back(enc_i(12'd9, 5'd0, F3_ADD, 5'd20, OP_IMM));
    sw_exp(5'd20, 12'h208, 32'h0);
    prog_q.push_back(enc_j(21'd0, 5'd0));
    load_prog();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("pc_trace%0d", i), 64'(dut.pc), 64'(pc_exp[i]));
      @(negedge clk);
    end
    run(3);
    chk("drain_ctl", 64'(exp_q.size()), 64'd0);

    // exit: wrong data first, then the exit pattern
    prog_q.push_back(enc_u(20'h1, 5'd5, OP_LUI));
    prog_q.push_back(enc_u(20'h1, 5'd6, OP_LUI));
    prog_q.push_back(enc_i(12'h234, 5'd6, F3_ADD, 5'd6, OP_IMM));
    prog_q.push_back(enc_s(12'h00C, 5'd6, 5'd5, F3_SW));
    exp_q.push_back({32'h100C, 32'h1234});
    prog_q.push_back(enc_u(20'hDEADC, 5'd7, OP_LUI));
    prog_q.push_back(enc_i(12'hEEF, 5'd7, F3_ADD, 5'd7, OP_IMM));
    prog_q.push_back(enc_s(12'h00C, 5'd7, 5'd5, F3_SW));
    exp_q.push_back({32'h100C, 32'hDEAD_BEEF});
    prog_q.push_back(enc_s(12'h200, 5'd6, 5'd0, F3_SW));
    prog_q.push_back(enc_j(21'd0, 5'd0));
    load_prog();
    run(4);
    chk("exit_wrong_data", 64'(exit), 64'd0);
    run(3);
    chk("exit_set", 64'(exit), 64'd1);
    chk("exit_pc", 64'(dut.pc), 64'h1C);
    chk("exit_wen_held", 64'(dmem_wen), 64'd0);
    chk("exit_store_done", 64'(mem[11'h403]), 64'hDEAD_BEEF);
    run(4);
    chk("exit_sticky", 64'(exit), 64'd1);
    chk("exit_pc_frozen", 64'(dut.pc), 64'h1C);
    chk("drain_exit", 64'(exp_q.size()), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rerst_exit", 64'(exit), 64'd0);
    chk("rerst_pc", 64'(dut.pc), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
